// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug controller: FSM state codes, default
// command codes and elaboration-time sizing helpers.
package debug_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DECODE  = 4'd1,
    ST_STEP    = 4'd2,
    ST_RUN     = 4'd3,
    ST_LOAD    = 4'd4,
    ST_SEND    = 4'd5,
    ST_WAIT_TX = 4'd6,
    ST_NEXT    = 4'd7
  } dbg_state_e;

  localparam logic [7:0] CMD_PC_CODE   = 8'h50;
  localparam logic [7:0] CMD_REGS_CODE = 8'h52;
  localparam logic [7:0] CMD_STEP_CODE = 8'h53;
  localparam logic [7:0] CMD_RUN_CODE  = 8'h43;
  localparam logic [7:0] CMD_HALT_CODE = 8'h48;
  localparam logic [7:0] NACK_CODE     = 8'h3F;

  // Address width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int bytes_per_word(input int nb, input int data_bits);
    return nb / data_bits;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Streams one NB-bit word out as DATA_BITS-wide bytes, MSB byte first, using a
// ready-pulse / done-pulse handshake with the UART transmitter.
module word_serializer
  import debug_pkg::*;
#(
  parameter int NB        = 32,
  parameter int DATA_BITS = 8,
  parameter int CW        = clog2_min1(bytes_per_word(NB, DATA_BITS) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NB-1:0]        word,
  input  logic [CW-1:0]        n_bytes,
  input  logic                 tx_done,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 done
);

  logic [NB-1:0] shreg;
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          accept;

  // A done pulse during the ready cycle itself belongs to no byte and is dropped.
  assign accept  = waiting && !tx_ready && tx_done;
  assign done    = accept && (cnt == CW'(1));
  assign tx_data = shreg[NB-1 -: DATA_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_ready <= 1'b0;
      waiting  <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (load) begin
        shreg    <= word;
        cnt      <= n_bytes;
        tx_ready <= 1'b1;
        waiting  <= 1'b1;
      end else if (accept) begin
        shreg <= shreg << DATA_BITS;
        cnt   <= cnt - CW'(1);
        if (cnt > CW'(1)) tx_ready <= 1'b1;
        else              waiting  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_debug_ctrl.sv
// UART-side debug controller for the MIPS core: decodes single-byte commands,
// drives step/run control and streams PC or register-file words back.
module uart_debug_ctrl
  import debug_pkg::*;
#(
  parameter int                   NB        = 32,
  parameter int                   DATA_BITS = 8,
  parameter int                   N_REGS    = 32,
  parameter logic [DATA_BITS-1:0] CMD_PC    = DATA_BITS'(CMD_PC_CODE),
  parameter logic [DATA_BITS-1:0] CMD_REGS  = DATA_BITS'(CMD_REGS_CODE),
  parameter logic [DATA_BITS-1:0] CMD_STEP  = DATA_BITS'(CMD_STEP_CODE),
  parameter logic [DATA_BITS-1:0] CMD_RUN   = DATA_BITS'(CMD_RUN_CODE),
  parameter logic [DATA_BITS-1:0] CMD_HALT  = DATA_BITS'(CMD_HALT_CODE),
  parameter logic [DATA_BITS-1:0] NACK      = DATA_BITS'(NACK_CODE)
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_uart_rx_ready,
  input  logic [DATA_BITS-1:0]            i_uart_rx_data,
  input  logic                            i_uart_tx_done,
  input  logic [NB-1:0]                   i_mips_pc,
  input  logic                            i_mips_halt,
  input  logic [NB-1:0]                   i_reg_data,
  output logic [clog2_min1(N_REGS)-1:0]   o_reg_addr,
  output logic                            o_mips_step,
  output logic                            o_mips_run,
  output logic                            o_uart_tx_ready,
  output logic [DATA_BITS-1:0]            o_uart_tx_data,
  output logic [3:0]                      o_state_debug
);

  localparam int BPW = bytes_per_word(NB, DATA_BITS);
  localparam int AW  = clog2_min1(N_REGS);
  localparam int CW  = clog2_min1(BPW + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

  dbg_state_e           state;
  logic [DATA_BITS-1:0] cmd_byte;
  logic                 src_pc;
  logic                 dump_regs;
  logic                 more_words;
  logic                 is_nack;
  logic                 ser_load;
  logic                 ser_done;
  logic [NB-1:0]        ser_word;
  logic [CW-1:0]        ser_bytes;
  logic                 halt_req;

  assign is_nack = (cmd_byte != CMD_PC) && (cmd_byte != CMD_REGS) &&
                   (cmd_byte != CMD_STEP) && (cmd_byte != CMD_RUN);

  assign halt_req = i_mips_halt || (i_uart_rx_ready && (i_uart_rx_data == CMD_HALT));

  // Unknown commands skip LOAD: the NACK byte is handed over straight from DECODE.
  always_comb begin
    ser_load  = 1'b0;
    ser_word  = '0;
    ser_bytes = CW'(BPW);
    if (state == ST_LOAD) begin
      ser_load = 1'b1;
      ser_word = src_pc ? i_mips_pc : i_reg_data;
    end else if ((state == ST_DECODE) && is_nack) begin
      ser_load                      = 1'b1;
      ser_word[NB-1 -: DATA_BITS]   = NACK;
      ser_bytes                     = CW'(1);
    end
  end

  word_serializer #(
    .NB        (NB),
    .DATA_BITS (DATA_BITS),
    .CW        (CW)
  ) u_serializer (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (ser_load),
    .word     (ser_word),
    .n_bytes  (ser_bytes),
    .tx_done  (i_uart_tx_done),
    .tx_ready (o_uart_tx_ready),
    .tx_data  (o_uart_tx_data),
    .done     (ser_done)
  );

  assign o_state_debug = state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      cmd_byte    <= '0;
      src_pc      <= 1'b0;
      dump_regs   <= 1'b0;
      more_words  <= 1'b0;
      o_reg_addr  <= '0;
      o_mips_step <= 1'b0;
      o_mips_run  <= 1'b0;
    end else begin
      o_mips_step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_uart_rx_ready) begin
            cmd_byte   <= i_uart_rx_data;
            o_reg_addr <= '0;
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          src_pc    <= 1'b1;
          dump_regs <= 1'b0;
          if (cmd_byte == CMD_PC) begin
            state <= ST_LOAD;
          end else if (cmd_byte == CMD_REGS) begin
            src_pc    <= 1'b0;
            dump_regs <= 1'b1;
            state     <= ST_LOAD;
          end else if (cmd_byte == CMD_STEP) begin
            o_mips_step <= 1'b1;
            state       <= ST_STEP;
          end else if (cmd_byte == CMD_RUN) begin
            if (i_mips_halt) begin
              state <= ST_LOAD;
            end else begin
              o_mips_run <= 1'b1;
              state      <= ST_RUN;
            end
          end else begin
            state <= ST_SEND;
          end
        end
        ST_STEP: state <= ST_LOAD;
        ST_RUN: begin
          if (halt_req) begin
            o_mips_run <= 1'b0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (i_uart_tx_done) begin
            if (ser_done) begin
              // Advance the address here so the read data is ready when LOAD samples it.
              more_words <= dump_regs && (o_reg_addr != LAST_IDX);
              if (dump_regs && (o_reg_addr != LAST_IDX)) o_reg_addr <= o_reg_addr + 1'b1;
              state <= ST_NEXT;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        ST_NEXT: state <= more_words ? ST_LOAD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
